bo_datapath: RTL
================

Name: bo_datapath

Overview:
Operative block (datapath) that sits directly downstream of the control block. It consumes LX, LS, LH, H, M0, M1 and M2 each cycle and executes one register-transfer step per clock on three working registers: RX, RS and RH. It exposes the result and registered status flags, which the control block can sample for branching.

Parameters:
WIDTH, 8, data width of input, registers and ALU
K, 3, constant operand selectable on the A-bus (M0=3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
x_in  in  WIDTH  external operand
LX  in  1  load enable for RX
LS  in  1  load enable for RS
LH  in  1  load enable for RH
H  in  1  ALU op select: 1 = add, 0 = multiply
M0  in  2  A-bus select
M1  in  2  B-bus select
M2  in  2  write-back select
y  out  WIDTH  result; mirrors RH
z_flag  out  1  registered: last value loaded into RS was zero
n_flag  out  1  registered: MSB of last value loaded into RS
ovf  out  1  sticky overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: RX=0, RS=0, RH=0 (so y=0), z_flag=1, n_flag=0, ovf=0.
  - These take effect immediately on reset assertion, without waiting for a clock edge.
  - No register loads while reset is high.
- A-bus mux (M0): 0=RX, 1=RS, 2=RH, 3=K.
- B-bus mux (M1): 0=RS, 1=x_in, 2=RX, 3=1.
- ALU (combinational, unsigned):
  - H=1: R = A+B. Overflow = carry out of bit WIDTH-1.
  - H=0: R = low WIDTH bits of A*B. Overflow = any nonzero bit in the upper WIDTH bits of the 2*WIDTH product.
- Write-back mux (M2): 0=R, 1=x_in, 2=R>>1 (logical shift, computed from the full-width truncated R), 3=A.
  - The write-back value W is shared by all destinations.
- Register loads, on the rising edge of clk:
  - LX: RX<=W. LS: RS<=W. LH: RH<=W.
  - Any combination may be asserted in the same cycle; all loaded registers receive the same W.
  - Sources are sampled before the edge (pre-edge values). RX<=RX+RS, for example, is a legal single-cycle step.
- Latency: one cycle from control inputs to the register update. y reflects RH, with no extra delay.
- Flags: z_flag and n_flag update only on cycles with LS=1, computed from W. Otherwise they hold.
- ovf, sticky:
  - Set when any L* is asserted, M2 is 0 or 2, and the ALU overflows.
  - Cleared when LX=1 and M2=1 (a new input is loaded).
  - Set and clear cannot coincide because M2 is shared. Otherwise ovf holds.
- No load enables asserted: all registers and flags hold. This is the idle/F-state behaviour.
- Undefined select values cannot occur: all four codes of every 2-bit mux are defined.

Optional Feature:
SAT_EN
- Defined: on ALU overflow, R saturates to 2^WIDTH-1 before write-back. ovf is still set.
- Not defined: R wraps (truncates). All other behaviour is identical.

Decomposition:
- Shared package bo_pkg holds:
  - select-code constants: A_RX, A_RS, A_RH, A_K; B_RS, B_X, B_RX, B_ONE; W_ALU, W_X, W_SHR, W_A
  - ALU op constants: OP_ADD=1, OP_MUL=0
- One sub-module, bo_alu, is natural: combinational add/multiply with overflow detection and the SAT_EN saturation logic.
- The bus muxes and the registers stay in bo_datapath.

Test Plan:
(WIDTH=8, K=3)
- Reset: assert reset asynchronously mid-cycle -> RX=RS=RH=y=0, z_flag=1, n_flag=0, ovf=0 immediately. An edge with LX=1 while reset is high leaves RX=0.
- Input load: LX=1, M2=1, x_in=0x25, ovf=1 beforehand -> next cycle RX=0x25, ovf=0; RS and RH unchanged.
- Add with overflow: RX=0xF0, RS=0x20, M0=0, M1=0, H=1, M2=0, LH=1 -> RH=0x10, ovf=1. With SAT_EN: RH=0xFF, ovf=1.
- Multiply into RS: RX=0x05, M0=3, M1=2, H=0, M2=0, LS=1 -> RS=0x0F, z_flag=0, n_flag=0, ovf unchanged. Then RX=0x60, same controls -> RS=0x20, ovf=1.
- Shift and flag: RS=0x01, M0=1, M1=3, H=1, M2=2, LS=1 -> RS=0x01 ((1+1)>>1). Then M2=3 with M0=2 (RH=0) and LS=1 -> RS=0, z_flag=1.
- Simultaneous loads: RS=0x0F, M0=1, M2=3, LX=LS=LH=1 -> RX=RS=RH=0x0F on the same edge. A following cycle with all L*=0 holds all values.

Source files
------------

// File: rtl/bo_pkg.sv
// Shared select codes and ALU op encodings for the bo_datapath operative block.
package bo_pkg;

   localparam logic [1:0] A_RX  = 2'd0;
   localparam logic [1:0] A_RS  = 2'd1;
   localparam logic [1:0] A_RH  = 2'd2;
   localparam logic [1:0] A_K   = 2'd3;

   localparam logic [1:0] B_RS  = 2'd0;
   localparam logic [1:0] B_X   = 2'd1;
   localparam logic [1:0] B_RX  = 2'd2;
   localparam logic [1:0] B_ONE = 2'd3;

   localparam logic [1:0] W_ALU = 2'd0;
   localparam logic [1:0] W_X   = 2'd1;
   localparam logic [1:0] W_SHR = 2'd2;
   localparam logic [1:0] W_A   = 2'd3;

   localparam logic OP_ADD = 1'b1;
   localparam logic OP_MUL = 1'b0;

endpackage

// File: rtl/bo_datapath_if.sv
// Control-to-datapath bus: control word and operand in, result and status flags out.
interface bo_datapath_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] x_in;
   logic             LX;
   logic             LS;
   logic             LH;
   logic             H;
   logic [1:0]       M0;
   logic [1:0]       M1;
   logic [1:0]       M2;
   logic [WIDTH-1:0] y;
   logic             z_flag;
   logic             n_flag;
   logic             ovf;

   modport master (
      output x_in, LX, LS, LH, H, M0, M1, M2,
      input  y, z_flag, n_flag, ovf
   );

   modport slave (
      input  x_in, LX, LS, LH, H, M0, M1, M2,
      output y, z_flag, n_flag, ovf
   );
endinterface

// File: rtl/bo_alu.sv
// Unsigned add/multiply with overflow detect; SAT_EN clamps the result to all-ones on overflow.
module bo_alu
   import bo_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] r,
   output logic             ovf
);

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   raw;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      if (op == OP_ADD) begin
         raw = sum[WIDTH-1:0];
         ovf = sum[WIDTH];
      end else begin
         raw = prod[WIDTH-1:0];
         ovf = |prod[2*WIDTH-1:WIDTH];
      end
`ifdef SAT_EN
      r = ovf ? {WIDTH{1'b1}} : raw;
`else
      r = raw;
`endif
   end

endmodule

// File: rtl/bo_datapath.sv
// Operative block: A/B bus muxes, ALU, write-back mux and RX/RS/RH with status flags.
// Optional saturation on overflow is enabled with the SAT_EN macro (see bo_alu).
module bo_datapath
   import bo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned K     = 3
) (
   input logic           clk,
   input logic           reset,
   bo_datapath_if.slave  bus
);

   localparam logic [WIDTH-1:0] KVal = WIDTH'(K);

   logic [WIDTH-1:0] rx_q, rs_q, rh_q;
   logic             z_q, n_q, ovf_q;
   logic [WIDTH-1:0] a_bus, b_bus, alu_r, w;
   logic             alu_ovf, any_load, ovf_set, ovf_clr;

   always_comb begin
      unique case (bus.M0)
         A_RX:    a_bus = rx_q;
         A_RS:    a_bus = rs_q;
         A_RH:    a_bus = rh_q;
         default: a_bus = KVal;
      endcase
      unique case (bus.M1)
         B_RS:    b_bus = rs_q;
         B_X:     b_bus = bus.x_in;
         B_RX:    b_bus = rx_q;
         default: b_bus = {{(WIDTH-1){1'b0}}, 1'b1};
      endcase
   end

   bo_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .a   (a_bus),
      .b   (b_bus),
      .op  (bus.H),
      .r   (alu_r),
      .ovf (alu_ovf)
   );

   always_comb begin
      unique case (bus.M2)
         W_ALU:   w = alu_r;
         W_X:     w = bus.x_in;
         W_SHR:   w = alu_r >> 1;
         default: w = a_bus;
      endcase
   end

   // Overflow only counts when the ALU result actually reaches a register.
   assign any_load = bus.LX | bus.LS | bus.LH;
   assign ovf_set  = any_load && (bus.M2 == W_ALU || bus.M2 == W_SHR) && alu_ovf;
   assign ovf_clr  = bus.LX && (bus.M2 == W_X);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_q  <= '0;
         rs_q  <= '0;
         rh_q  <= '0;
         z_q   <= 1'b1;
         n_q   <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (bus.LX) rx_q <= w;
         if (bus.LH) rh_q <= w;
         if (bus.LS) begin
            rs_q <= w;
            z_q  <= (w == '0);
            n_q  <= w[WIDTH-1];
         end
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign bus.y      = rh_q;
   assign bus.z_flag = z_q;
   assign bus.n_flag = n_q;
   assign bus.ovf    = ovf_q;

endmodule
